// File: rtl/instr_cache_pkg.sv
// Shared types and field widths for the direct-mapped instruction cache.
// Address layout: PC[3:2] word offset, PC[6:4] line index, PC[9:7] tag.
package instr_cache_pkg;
   localparam int TAG_W   = 3;
   localparam int IDX_W   = 3;
   localparam int OFF_W   = 2;
   localparam int WORD_W  = 32;
   localparam int BLOCK_W = 128;

   typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

   function automatic logic [WORD_W-1:0] block_word(input logic [BLOCK_W-1:0] blk,
                                                    input logic [OFF_W-1:0]   off);
      return blk[off*WORD_W +: WORD_W];
   endfunction
endpackage

// File: rtl/instr_cache_if.sv
// Fetch-side and memory-side bus of the instruction cache.
// slave = cache view, master = PC unit plus instruction memory.
interface instr_cache_if;
   logic [31:0]  PC;
   logic [31:0]  INSTRUCTION;
   logic         BUSYWAIT;
   logic         MEM_READ;
   logic [5:0]   MEM_ADDRESS;
   logic [127:0] MEM_READDATA;
   logic         MEM_BUSYWAIT;

   modport slave  (input  PC, MEM_READDATA, MEM_BUSYWAIT,
                   output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS);
   modport master (output PC, MEM_READDATA, MEM_BUSYWAIT,
                   input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS);
endinterface

// File: rtl/icache_line_array.sv
// Valid/tag/data storage: one synchronous write port, combinational read.
// Reset clears only the valid bits; tags and data keep their contents.
module icache_line_array
   import instr_cache_pkg::*;
#(
   parameter int NUM_BLOCKS = 8,
   parameter int BLK_BITS   = BLOCK_W
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                we,
   input  logic [IDX_W-1:0]    idx,
   input  logic [TAG_W-1:0]    wtag,
   input  logic [BLK_BITS-1:0] wdata,
   output logic                rvalid,
   output logic [TAG_W-1:0]    rtag,
   output logic [BLK_BITS-1:0] rdata
);
   logic [NUM_BLOCKS-1:0]               valid;
   logic [NUM_BLOCKS-1:0][TAG_W-1:0]    tags;
   logic [NUM_BLOCKS-1:0][BLK_BITS-1:0] data;

   // Reset outranks a write landing on the same edge.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         valid <= '0;
      end else if (we) begin
         valid[idx] <= 1'b1;
         tags[idx]  <= wtag;
         data[idx]  <= wdata;
      end
   end

   assign rvalid = valid[idx];
   assign rtag   = tags[idx];
   assign rdata  = data[idx];
endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache, 8 lines of 4 words.
// Miss flow: IDLE -> MEM_READ (until memory ready) -> UPDATE -> IDLE hit.
module instr_cache
   import instr_cache_pkg::*;
#(
   parameter int NUM_BLOCKS      = 8,
   parameter int WORDS_PER_BLOCK = 4
) (
   input  logic          CLK,
   input  logic          RESET,
   instr_cache_if.slave  bus
);
   localparam int BLK_BITS = WORDS_PER_BLOCK * WORD_W;

   logic [TAG_W-1:0]    pc_tag;
   logic [IDX_W-1:0]    pc_idx;
   logic [OFF_W-1:0]    pc_off;
   logic                line_valid;
   logic [TAG_W-1:0]    line_tag;
   logic [BLK_BITS-1:0] line_data;
   logic                hit;
   logic                fill;
   logic                mem_rd_q;
   state_t              state;
   logic                unused_pc_bits;

   assign pc_tag = bus.PC[9:7];
   assign pc_idx = bus.PC[6:4];
   assign pc_off = bus.PC[3:2];
   assign unused_pc_bits = ^{bus.PC[31:10], bus.PC[1:0]};

   // PC is frozen while stalled, so the index of the miss is still on PC.
   assign fill = (state == MEM_READ) && !bus.MEM_BUSYWAIT && !RESET;

   icache_line_array #(
      .NUM_BLOCKS (NUM_BLOCKS),
      .BLK_BITS   (BLK_BITS)
   ) u_lines (
      .CLK    (CLK),
      .RESET  (RESET),
      .we     (fill),
      .idx    (pc_idx),
      .wtag   (pc_tag),
      .wdata  (bus.MEM_READDATA),
      .rvalid (line_valid),
      .rtag   (line_tag),
      .rdata  (line_data)
   );

   assign hit = line_valid && (line_tag == pc_tag);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state    <= IDLE;
         mem_rd_q <= 1'b0;
      end else begin
         case (state)
            IDLE: if (!hit) begin
               state    <= MEM_READ;
               mem_rd_q <= 1'b1;
            end
            MEM_READ: if (!bus.MEM_BUSYWAIT) begin
               state    <= UPDATE;
               mem_rd_q <= 1'b0;
            end
            UPDATE: state <= IDLE;
            default: begin
               state    <= IDLE;
               mem_rd_q <= 1'b0;
            end
         endcase
      end
   end

   // A miss stalls in the same cycle it is seen, before the FSM moves.
   assign bus.BUSYWAIT    = (state != IDLE) || !hit;
   assign bus.MEM_READ    = mem_rd_q;
   assign bus.MEM_ADDRESS = mem_rd_q ? bus.PC[9:4] : 6'd0;
   assign bus.INSTRUCTION = bus.BUSYWAIT ? 32'h0 : block_word(line_data, pc_off);
endmodule

// File: tb/tb_instr_cache.sv
// Scoreboard bench for instr_cache: stimulus queues expected fetch results,
// a negedge monitor retires them when BUSYWAIT drops.
module tb_instr_cache;
   logic CLK = 1'b0;
   logic RESET = 1'b1;
   instr_cache_if bus();

   instr_cache #(.NUM_BLOCKS(8), .WORDS_PER_BLOCK(4)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   // Reference memory: 4-cycle latency, word = C0DE0000 | byte address.
   localparam int LAT = 4;
   int mem_cnt = 0;

   function automatic logic [31:0] mem_word(input logic [5:0] a, input logic [1:0] w);
      return 32'hC0DE_0000 | {22'd0, a, w, 2'b00};
   endfunction

   always_comb begin
      bus.MEM_READDATA = '0;
      for (int w = 0; w < 4; w++)
         bus.MEM_READDATA[32*w +: 32] = mem_word(bus.MEM_ADDRESS, 2'(w));
   end
   assign bus.MEM_BUSYWAIT = bus.MEM_READ && (mem_cnt < LAT - 1);
   always @(posedge CLK) mem_cnt <= bus.MEM_READ ? mem_cnt + 1 : 0;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      int          stalls;
      int          reads;
   } exp_t;

   exp_t q[$];
   int   done_cnt = 0;
   int   busy_cnt = 0;
   int   rd_cnt   = 0;
   int   total_mr = 0;
   logic prev_mr  = 1'b0;
   logic nz_busy  = 1'b0;
   logic [5:0] seen_addr = '0;

   always @(negedge CLK) begin
      exp_t e;
      if (bus.MEM_READ && !prev_mr) total_mr++;
      if (q.size() > 0) begin
         if (bus.MEM_READ) begin
            if (!prev_mr) rd_cnt++;
            seen_addr = bus.MEM_ADDRESS;
         end
         if (bus.BUSYWAIT) begin
            busy_cnt++;
            if (bus.INSTRUCTION != 32'h0) nz_busy = 1'b1;
         end else begin
            e = q.pop_front();
            chk($sformatf("instr pc=%h", e.pc), bus.INSTRUCTION, e.instr);
            chk($sformatf("stalls pc=%h", e.pc), 32'(busy_cnt), 32'(e.stalls));
            chk($sformatf("mem_reads pc=%h", e.pc), 32'(rd_cnt), 32'(e.reads));
            chk($sformatf("instr_zero_while_busy pc=%h", e.pc), 32'(nz_busy), 32'd0);
            if (e.reads > 0)
               chk($sformatf("mem_address pc=%h", e.pc), 32'(seen_addr), 32'(e.pc[9:4]));
            busy_cnt = 0;
            rd_cnt   = 0;
            nz_busy  = 1'b0;
            done_cnt++;
         end
      end
      prev_mr = bus.MEM_READ;
   end

   // Called just after a posedge; returns on the posedge closing the hit cycle.
   task automatic issue(input logic [31:0] pc, input logic [31:0] instr,
                        input int stalls, input int reads);
      exp_t e;
      int   n;
      e.pc = pc; e.instr = instr; e.stalls = stalls; e.reads = reads;
      n = done_cnt;
      q.push_back(e);
      bus.PC = pc;
      for (int i = 0; i < 50; i++) begin
         @(posedge CLK);
         if (done_cnt != n) break;
      end
      if (done_cnt == n) begin
         checks++;
         errors++;
         $display("FAIL timeout pc=%h: no BUSYWAIT release within 50 cycles", pc);
         q.delete();
      end
   endtask

   task automatic fetch(input logic [31:0] pc, input logic [31:0] instr,
                        input int stalls, input int reads);
      #1;
      issue(pc, instr, stalls, reads);
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      bus.PC = 32'h0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("reset MEM_READ", 32'(bus.MEM_READ), 32'd0);
      chk("reset MEM_ADDRESS", 32'(bus.MEM_ADDRESS), 32'd0);
      chk("reset BUSYWAIT", 32'(bus.BUSYWAIT), 32'd1);
      chk("reset INSTRUCTION", bus.INSTRUCTION, 32'h0);
      @(posedge CLK);
      #1 RESET = 1'b0;
   endtask

   // Reset lands at the edge ending the k-th MEM_READ cycle, then refetch.
   task automatic abort_fill(input logic [31:0] pc, input int k);
      #1 bus.PC = pc;
      repeat (k) @(posedge CLK);
      #1 RESET = 1'b1;
      @(posedge CLK);
      #1 RESET = 1'b0;
      chk($sformatf("abort%0d MEM_READ", k), 32'(bus.MEM_READ), 32'd0);
      chk($sformatf("abort%0d BUSYWAIT", k), 32'(bus.BUSYWAIT), 32'd1);
      issue(pc, mem_word(pc[9:4], pc[3:2]), 6, 1);
   endtask

   logic       mv[8];
   logic [2:0] mt[8];

   initial begin
      int mr_base;
      int misses;
      bus.PC = 32'h0;

      do_reset();
      issue(32'h000, 32'hC0DE_0000, 6, 1);
      fetch(32'h004, 32'hC0DE_0004, 0, 0);
      fetch(32'h008, 32'hC0DE_0008, 0, 0);
      fetch(32'h00C, 32'hC0DE_000C, 0, 0);
      fetch(32'h080, 32'hC0DE_0080, 6, 1);
      fetch(32'h084, 32'hC0DE_0084, 0, 0);
      fetch(32'h000, 32'hC0DE_0000, 6, 1);
      fetch(32'h3FC, 32'hC0DE_03FC, 6, 1);
      fetch(32'hFFFF_F3FC, 32'hC0DE_03FC, 0, 0);
      fetch(32'h013, 32'hC0DE_0010, 6, 1);

      abort_fill(32'h100, 2);
      fetch(32'h000, 32'hC0DE_0000, 6, 1);
      fetch(32'h104, 32'hC0DE_0104, 6, 1);
      abort_fill(32'h208, 4);
      fetch(32'h20C, 32'hC0DE_020C, 0, 0);

      do_reset();
      for (int i = 0; i < 8; i++) mv[i] = 1'b0;
      misses  = 0;
      mr_base = total_mr;
      for (int i = 0; i < 40; i++) begin
         logic [31:0] r, pc;
         logic [2:0]  tg, ix;
         logic [1:0]  of;
         logic        miss;
         r  = $urandom;
         tg = 3'($urandom_range(0, 1));
         ix = 3'($urandom_range(0, 7));
         of = 2'($urandom_range(0, 3));
         pc = {r[31:10], tg, ix, of, r[1:0]};
         miss = !mv[ix] || (mt[ix] != tg);
         if (miss) begin
            misses++;
            mv[ix] = 1'b1;
            mt[ix] = tg;
         end
         if (i == 0) issue(pc, mem_word({tg, ix}, of), miss ? 6 : 0, miss ? 1 : 0);
         else        fetch(pc, mem_word({tg, ix}, of), miss ? 6 : 0, miss ? 1 : 0);
      end
      chk("random MEM_READ count", 32'(total_mr - mr_base), 32'(misses));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/instr_cache.md
INSTR_CACHE -- requirements
Module: instr_cache

Interface
REQ-001 Parameter NUM_BLOCKS, default 8, number of direct-mapped cache lines; only the value 8 is supported.
REQ-002 Parameter WORDS_PER_BLOCK, default 4, number of 32-bit instructions per line; only the value 4 is supported.
REQ-003 CLK  in  1  single clock; all state updates on posedge CLK.
REQ-004 RESET  in  1  synchronous, active-high reset, sampled on posedge CLK.
REQ-005 PC  in  32  instruction byte address from the PC unit.
REQ-006 INSTRUCTION  out  32  fetched instruction for PC.
REQ-007 BUSYWAIT  out  1  stall request to the PC unit; PC SHALL be held while high.
REQ-008 MEM_READ  out  1  read request to instruction memory.
REQ-009 MEM_ADDRESS  out  6  block address to memory, equal to PC[9:4].
REQ-010 MEM_READDATA  in  128  returned block; word n occupies bits [32n+31:32n].
REQ-011 MEM_BUSYWAIT  in  1  memory busy; read data is valid in the cycle it falls low while MEM_READ is high.

Function
REQ-012 Address split: PC[1:0] ignored, offset = PC[3:2], index = PC[6:4], tag = PC[9:7], and PC[31:10] ignored.
REQ-013 Storage per line: valid bit, 3-bit tag, 128-bit data.
REQ-014 Hit = valid[index] AND tag[index] equals the PC tag, evaluated combinationally from the current PC.
REQ-015 FSM states: IDLE, MEM_READ, UPDATE.
REQ-016 IDLE on a hit: INSTRUCTION = data[index] word[offset], BUSYWAIT = 0, zero added stall cycles.
REQ-017 IDLE on a miss: BUSYWAIT = 1 combinationally in the same cycle, and the state goes to MEM_READ at the next edge.
REQ-018 MEM_READ: MEM_READ = 1, MEM_ADDRESS = PC[9:4], BUSYWAIT = 1; the state stays in MEM_READ while MEM_BUSYWAIT = 1.
REQ-019 MEM_READ with MEM_BUSYWAIT = 0 at the edge: capture MEM_READDATA into data[index], set tag[index] to the PC tag and valid[index] to 1, then go to UPDATE.
REQ-020 UPDATE: MEM_READ = 0, BUSYWAIT = 1 for exactly one cycle, then go to IDLE, where the access is a hit.
REQ-021 Miss penalty = memory latency + 2 cycles; BUSYWAIT falls in the IDLE cycle that follows UPDATE.
REQ-022 A miss always replaces the indexed line; there is no dirty state and no write path.
REQ-023 PC SHALL NOT change while BUSYWAIT = 1; under that condition the line filled is the one for the PC that missed.
REQ-024 INSTRUCTION is don't-care while BUSYWAIT = 1 and SHALL be driven 32'h0 in that case.
REQ-025 MEM_READ and MEM_ADDRESS are 0 in every state other than MEM_READ.

Reset
REQ-026 When RESET = 1 at an edge: all valid bits clear, the state goes to IDLE, and tags and data are left unchanged.
REQ-027 RESET during MEM_READ aborts the fill: the line is not written and MEM_READ = 0 in the next cycle.
REQ-028 RESET has priority over the fill capture when both occur at the same edge.
REQ-029 After reset, every first access misses.

Structure
REQ-030 A shared package holds: the state enum (IDLE, MEM_READ, UPDATE), field widths (TAG_W = 3, IDX_W = 3, OFF_W = 2), and BLOCK_W = 128.
REQ-031 There is one sub-module, icache_line_array, holding valid/tag/data storage with a single synchronous write port and a combinational read.
REQ-032 The FSM and hit logic live in instr_cache; there are no other sub-modules.

Verification
REQ-033 Reset, then PC = 0x000, memory latency 4 cycles -> BUSYWAIT high for 6 cycles, one MEM_READ with MEM_ADDRESS = 0, then INSTRUCTION = word0 of block 0.
REQ-034 Sequential PC = 0x004, 0x008, 0x00C after the fill -> hits, BUSYWAIT = 0, words 1–3 returned and no MEM_READ.
REQ-035 PC = 0x080 (same index 0, tag 1) -> miss, line replaced; then PC = 0x000 -> miss again, showing the conflict eviction.
REQ-036 PC = 0x3FC -> MEM_ADDRESS = 0x3F, index 7, INSTRUCTION = word3; then PC = 0xFFFFF3FC -> hit, because the upper bits are ignored.
REQ-037 RESET asserted in the 2nd cycle of MEM_READ -> MEM_READ = 0 next cycle and state IDLE; re-presenting the same PC misses and issues a new MEM_READ.
REQ-038 A random PC stream against a reference memory model -> every cycle with BUSYWAIT = 0 returns the correct instruction, and the MEM_READ count equals the model's miss count.
